result_writer: RTL

RESULT_WRITER -- requirements
Module: result_writer

---
 rtl/result_writer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/result_writer.sv
// -----------------------------------------------------------------------------
// result_writer
//
// Purpose:
//   Takes the per-row results drained from an N1 x N2 systolic array. It turns
//   each valid beat into a write into that row's result bank. Each row walks its
//   own bank address sequence, from column to column-block to row-block, with a
//   fixed one-cycle latency. When every row has finished a full frame, done
//   pulses once, which means the whole M x M result is in the banks.
//
// Parameters:
//   D_W_ACC : accumulator / result width
//   N1      : systolic rows (one result bank per row)
//   N2      : systolic columns (results per row per tile)
//   M       : matrix dimension (power of two, multiple of N1 and N2)
//   AW      : bank address width, $clog2((M*M)/N1)
//
// Ports:
//   clk        : single clock, all logic on the rising edge
//   rst        : synchronous, active-low reset
//   D[N1]      : per-row result drained from the array
//   valid_D    : per-row qualifier for D
//   wr_en_D    : per-bank write enable (registered)
//   wr_addr_D  : per-bank write address (registered, holds when idle)
//   wr_data_D  : per-bank write data (registered, holds when idle)
//   done       : one-cycle pulse when all rows have written a full frame
//   overrun    : (only with RESULT_WRITER_OVERRUN_EN) sticky flag. It sets when
//                a row that has already finished wraps a second frame before
//                done fires.
//
// Configuration macro:
//   RESULT_WRITER_OVERRUN_EN : adds the overrun output and its detection logic.
// -----------------------------------------------------------------------------
module result_writer #(
  parameter int D_W_ACC = 16,
  parameter int N1      = 4,
  parameter int N2      = 4,
  parameter int M       = 8,
  localparam int AW     = $clog2((M*M)/N1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_W_ACC-1:0] D         [N1],
  input  logic [N1-1:0]      valid_D,
  output logic [N1-1:0]      wr_en_D,
  output logic [AW-1:0]      wr_addr_D [N1],
  output logic [D_W_ACC-1:0] wr_data_D [N1],
  output logic               done
`ifdef RESULT_WRITER_OVERRUN_EN
  ,
  output logic               overrun
`endif
);

  // Counter widths are forced to at least one bit. This keeps degenerate
  // shapes, where a dimension has only one step, legal.
  localparam int COL_CNT  = N2;
  localparam int CBLK_CNT = M / N2;
  localparam int RBLK_CNT = M / N1;
  localparam int CW  = (COL_CNT  > 1) ? $clog2(COL_CNT)  : 1;
  localparam int CBW = (CBLK_CNT > 1) ? $clog2(CBLK_CNT) : 1;
  localparam int RBW = (RBLK_CNT > 1) ? $clog2(RBLK_CNT) : 1;

  localparam logic [CW-1:0]  COL_LAST  = CW'(COL_CNT - 1);
  localparam logic [CBW-1:0] CBLK_LAST = CBW'(CBLK_CNT - 1);
  localparam logic [RBW-1:0] RBLK_LAST = RBW'(RBLK_CNT - 1);

  // The row-block stride M can equal 2**AW only when there is a single row
  // block. Its product is then always zero, so truncating M here is harmless.
  localparam logic [AW-1:0] ROW_STRIDE = AW'(M);
  localparam logic [AW-1:0] COL_STRIDE = AW'(N2);

  logic [CW-1:0]  r_col     [N1];
  logic [CBW-1:0] r_colBlk  [N1];
  logic [RBW-1:0] r_rowBlk  [N1];
  logic [N1-1:0]  r_finished;
`ifdef RESULT_WRITER_OVERRUN_EN
  logic           r_overrun;
`endif

  logic [AW-1:0]  w_addr    [N1];
  logic [N1-1:0]  w_wrap;
  logic [N1-1:0]  w_flagsNext;
  logic           w_allDone;

  // Bank address for each row comes from its three counters. The frame wrap
  // is a valid beat that lands while all three counters sit at their last
  // value. Finished flags set by this cycle's wraps count toward done, so done
  // fires on the edge that registers the last row's final write.
  always_comb begin
    w_wrap = '0;
    for (int i = 0; i < N1; i++) begin
      w_addr[i] = AW'(r_rowBlk[i]) * ROW_STRIDE
                + AW'(r_colBlk[i]) * COL_STRIDE
                + AW'(r_col[i]);
      w_wrap[i] = valid_D[i] && (r_col[i] == COL_LAST) &&
                  (r_colBlk[i] == CBLK_LAST) && (r_rowBlk[i] == RBLK_LAST);
    end
    w_flagsNext = r_finished | w_wrap;
    w_allDone   = &w_flagsNext;
  end

  // Per-row write registers and address counters, plus the shared
  // finished-flag and done tracking. A row that has already finished simply
  // keeps writing from address 0, because its counters have wrapped. Its flag
  // stays set until done clears all flags together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en_D    <= '0;
      done       <= 1'b0;
      r_finished <= '0;
      for (int i = 0; i < N1; i++) begin
        wr_addr_D[i] <= '0;
        wr_data_D[i] <= '0;
        r_col[i]     <= '0;
        r_colBlk[i]  <= '0;
        r_rowBlk[i]  <= '0;
      end
    end else begin
      wr_en_D <= valid_D;
      for (int i = 0; i < N1; i++) begin
        if (valid_D[i]) begin
          wr_addr_D[i] <= w_addr[i];
          wr_data_D[i] <= D[i];
          if (r_col[i] == COL_LAST) begin
            r_col[i] <= '0;
            if (r_colBlk[i] == CBLK_LAST) begin
              r_colBlk[i] <= '0;
              if (r_rowBlk[i] == RBLK_LAST) begin
                r_rowBlk[i] <= '0;
              end else begin
                r_rowBlk[i] <= r_rowBlk[i] + RBW'(1);
              end
            end else begin
              r_colBlk[i] <= r_colBlk[i] + CBW'(1);
            end
          end else begin
            r_col[i] <= r_col[i] + CW'(1);
          end
        end
      end
      done       <= w_allDone;
      r_finished <= w_allDone ? '0 : w_flagsNext;
    end
  end

`ifdef RESULT_WRITER_OVERRUN_EN
  // Overrun is sticky. It sets when a row that is already finished wraps
  // another frame before done has released the flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (|(r_finished & w_wrap)) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`endif

endmodule
